// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a 4-digit multiplexed active-low 7-segment display.
// Samples each digit once per anode activation and publishes BCD after STABLE_FRAMES identical frames.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       fastclk,
    input  logic       rst,
    input  logic [3:0] Ao,
    input  logic [6:0] s,
    input  logic       Do,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] dp,
    output logic       valid,
    output logic       err,
    output logic       frame_strobe,
    output logic       stale
);

    typedef struct packed {
        logic [3:0] bcd;
        logic       dp;
    } digit_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TO_HIT     = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    ao_r;
    logic [6:0]    s_r;
    logic          do_r;
    logic [SW-1:0] settle;
    logic          sampled;
    logic [TW-1:0] tcnt;
    logic [3:0]    mask, mask_nxt;
    logic [MW-1:0] match;
    digit_t [3:0]  shadow, cand, pub;

    logic       onehot, sample, complete, timeout, publish, cand_err;
    logic [1:0] idx;
    digit_t     sdig;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: seg_decode = 4'h0;
            7'b1001111: seg_decode = 4'h1;
            7'b0010010: seg_decode = 4'h2;
            7'b0000110: seg_decode = 4'h3;
            7'b1001100: seg_decode = 4'h4;
            7'b0100100: seg_decode = 4'h5;
            7'b0100000: seg_decode = 4'h6;
            7'b0001111: seg_decode = 4'h7;
            7'b0000000: seg_decode = 4'h8;
            7'b0000100: seg_decode = 4'h9;
            7'b1111111: seg_decode = 4'hF;
            default:    seg_decode = 4'hE;
        endcase
    endfunction

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (ao_r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    assign sample   = onehot && !sampled && (settle == SETTLE_HIT);
    assign complete = (mask == 4'hF);
    assign timeout  = (tcnt == TO_HIT) && !sample;
    assign publish  = (match == MATCH_MAX) && ((cand != pub) || !valid) && !timeout;
    assign sdig     = '{bcd: seg_decode(s_r), dp: ~do_r};

    // A completing frame frees the mask in the same cycle a new sample may land.
    always_comb begin
        mask_nxt = complete ? 4'h0 : mask;
        if (sample) mask_nxt[idx] = 1'b1;
    end

    always_comb begin
        cand_err = 1'b0;
        for (int i = 0; i < 4; i++)
            if (cand[i].bcd == 4'hE) cand_err = 1'b1;
    end

    always_ff @(posedge fastclk) begin
        if (rst) begin
            ao_r         <= 4'hF;
            s_r          <= 7'h7F;
            do_r         <= 1'b1;
            settle       <= '0;
            sampled      <= 1'b0;
            tcnt         <= '0;
            mask         <= 4'h0;
            match        <= '0;
            shadow       <= '0;
            cand         <= '0;
            pub          <= '0;
            valid        <= 1'b0;
            err          <= 1'b0;
            frame_strobe <= 1'b0;
            stale        <= 1'b0;
        end else begin
            ao_r         <= Ao;
            s_r          <= s;
            do_r         <= Do;
            frame_strobe <= 1'b0;

            if (Ao != ao_r) begin
                settle  <= '0;
                sampled <= 1'b0;
            end else begin
                if (settle != SETTLE_MAX) settle <= settle + SW'(1);
                if (sample) sampled <= 1'b1;
            end

            if (sample)              tcnt <= '0;
            else if (tcnt != TO_HIT) tcnt <= tcnt + TW'(1);

            if (sample) shadow[idx] <= sdig;
            mask <= mask_nxt;

            if (complete) begin
                if (shadow == cand) begin
                    if (match != MATCH_MAX) match <= match + MW'(1);
                end else begin
                    cand  <= shadow;
                    match <= MW'(1);
                end
            end

            if (publish) begin
                pub          <= cand;
                frame_strobe <= 1'b1;
                valid        <= 1'b1;
                stale        <= 1'b0;
                err          <= cand_err;
            end

            // Stale display: drop any partial progress but keep showing the last value.
            if (timeout) begin
                stale <= 1'b1;
                valid <= 1'b0;
                mask  <= 4'h0;
                match <= '0;
            end
        end
    end

    assign bcd0 = pub[0].bcd;
    assign bcd1 = pub[1].bcd;
    assign bcd2 = pub[2].bcd;
    assign bcd3 = pub[3].bcd;
    assign dp   = {pub[3].dp, pub[2].dp, pub[1].dp, pub[0].dp};

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed + randomized scans of a multiplexed display, checked against a frame-level model
// of the publish rules (decode table lookup, stability count, timeout).
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 200;

    logic       fastclk = 1'b0;
    logic       rst;
    logic [3:0] Ao;
    logic [6:0] s;
    logic       Do;
    logic [3:0] bcd0, bcd1, bcd2, bcd3, dp;
    logic       valid, err, frame_strobe, stale;

    seg7_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .STABLE_FRAMES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .fastclk     (fastclk),
        .rst         (rst),
        .Ao          (Ao),
        .s           (s),
        .Do          (Do),
        .bcd0        (bcd0),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .bcd3        (bcd3),
        .dp          (dp),
        .valid       (valid),
        .err         (err),
        .frame_strobe(frame_strobe),
        .stale       (stale)
    );

    always #5 fastclk = ~fastclk;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;

    always @(negedge fastclk) if (frame_strobe === 1'b1) strobes++;

    // Reference model: frame key = {digit3..digit0, dp3..dp0}
    logic [6:0]  pat [10];
    logic [19:0] m_cand, m_pub;
    int          m_cnt, exp_strobes;
    bit          m_valid, m_stale, m_err;

    function automatic logic [3:0] ref_dec(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (p == pat[k]) return 4'(k);
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        if (code < 4'd10)  return pat[code];
        if (code == 4'hF)  return 7'h7F;
        return 7'b1111110;
    endfunction

    task automatic model_reset();
        m_cand = '0; m_pub = '0; m_cnt = 0;
        m_valid = 0; m_stale = 0; m_err = 0;
    endtask

    task automatic model_frame(input logic [3:0][6:0] sg, input logic [3:0] dpv);
        logic [19:0] key;
        for (int i = 0; i < 4; i++) begin
            key[4 + 4*i +: 4] = ref_dec(sg[i]);
            key[i]            = dpv[i];
        end
        if (key == m_cand) m_cnt = (m_cnt < STABLE) ? m_cnt + 1 : STABLE;
        else begin
            m_cand = key;
            m_cnt  = 1;
        end
        if (m_cnt == STABLE && (m_cand != m_pub || !m_valid)) begin
            m_pub   = m_cand;
            m_valid = 1;
            m_stale = 0;
            m_err   = 0;
            for (int i = 0; i < 4; i++)
                if (m_pub[4 + 4*i +: 4] == 4'hE) m_err = 1;
            exp_strobes++;
        end
    endtask

    task automatic model_timeout();
        m_stale = 1; m_valid = 0; m_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bcd"},    32'({bcd3, bcd2, bcd1, bcd0}), 32'(m_pub[19:4]));
        chk({tag, ".dp"},     32'(dp),           32'(m_pub[3:0]));
        chk({tag, ".valid"},  32'(valid),        32'(m_valid));
        chk({tag, ".err"},    32'(err),          32'(m_err));
        chk({tag, ".stale"},  32'(stale),        32'(m_stale));
        chk({tag, ".strobes"}, 32'(strobes),     32'(exp_strobes));
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] sg, input logic d, input int n);
        Ao = a; s = sg; Do = d;
        repeat (n) @(negedge fastclk);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, 1'b1, n);
    endtask

    // One scan 0..3; with glitch, a short sub-settle pulse on digit 2 precedes digit 3.
    task automatic scan(input logic [15:0] codes, input logic [3:0] dpv, input int hold, input bit glitch);
        logic [3:0][6:0] sg;
        for (int i = 0; i < 4; i++) sg[i] = seg_of(codes[4*i +: 4]);
        for (int i = 0; i < 4; i++) begin
            if (glitch && i == 3) begin
                idle(2);
                drive(4'b1011, 7'b1111110, 1'b1, 3);
                idle(2);
            end
            drive(4'(~(4'b0001 << i)), sg[i], ~dpv[i], hold);
        end
        model_frame(sg, dpv);
    endtask

    task automatic scan_n(input logic [15:0] codes, input logic [3:0] dpv, input int n);
        for (int k = 0; k < n; k++) scan(codes, dpv, 20, 1'b0);
    endtask

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        exp_strobes = 0;
        model_reset();
        rst = 1'b1; Ao = 4'hF; s = 7'h7F; Do = 1'b1;
        repeat (3) @(negedge fastclk);
        rst = 1'b0;
        @(negedge fastclk);
        check_all("reset");

        scan_n(16'h0150, 4'b0000, 2); idle(5);
        check_all("t1_publish");

        scan_n(16'h0150, 4'b0000, 5); idle(5);
        check_all("t2_repeat");

        scan_n(16'h0140, 4'b0000, 1);
        scan_n(16'h0150, 4'b0000, 1); idle(5);
        check_all("t3_oneframe");
        scan_n(16'h0140, 4'b0000, 2); idle(5);
        check_all("t3_change");

        scan(16'h0140, 4'b0000, 20, 1'b1);
        scan(16'h0140, 4'b0000, 20, 1'b1); idle(5);
        check_all("t4_glitch");
        scan_n(16'h01E0, 4'b0000, 2); idle(5);
        check_all("t4_undecodable");
        scan_n(16'h01F0, 4'b0000, 2); idle(5);
        check_all("t4_blank");

        idle(100);
        chk("t5_not_yet_stale", 32'(stale), 32'd0);
        idle(150);
        model_timeout();
        check_all("t5_stale");
        scan_n(16'h0150, 4'b0000, 2); idle(5);
        check_all("t5_resume");

        scan(16'h1234, 4'b0000, 20, 1'b0);
        drive(4'b1110, seg_of(4'h7), 1'b1, 20);
        drive(4'b1101, seg_of(4'h8), 1'b1, 20);
        rst = 1'b1; idle(2); rst = 1'b0;
        model_reset();
        @(negedge fastclk);
        check_all("t6_reset");
        scan_n(16'h9999, 4'b0100, 2); idle(5);
        check_all("t6_9999");

        for (int r = 0; r < 8; r++) begin
            logic [15:0] codes;
            logic [3:0]  dpv;
            int          reps, hold;
            for (int i = 0; i < 4; i++) codes[4*i +: 4] = 4'($urandom_range(0, 15));
            dpv  = 4'($urandom);
            reps = $urandom_range(1, 3);
            hold = $urandom_range(SETTLE, 10);
            for (int k = 0; k < reps; k++) scan(codes, dpv, hold, 1'b0);
            idle(5);
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
